// File: rtl/drv_mon_pkg.sv
// Shared types and constants for the driver FIFO monitor readout path.
// The optional checksum word is selected by the DRV_MON_READOUT_CSUM_EN macro.
package drv_mon_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        ADDR = 3'd2,
        VCTR = 3'd3,
        STAT = 3'd4,
        CSUM = 3'd5
    } rd_state_t;

    localparam logic [15:0] HDR_MAGIC = 16'hD0A5;

    // Frame length in words: header, all bins packed two per word, status, optional checksum
    function automatic logic [7:0] frame_len(input int unsigned num_bins, input bit csum_en);
        return 8'(num_bins + 32'd2 + (csum_en ? 32'd1 : 32'd0));
    endfunction

endpackage

// File: rtl/driver_monitor_frame_mux.sv
// Combinational word selector for the statistics readout frame.
// The checksum word is only reachable when DRV_MON_READOUT_CSUM_EN is defined in the top.
module driver_monitor_frame_mux
    import drv_mon_pkg::*;
#(
    parameter int unsigned NUM_BINS = 16,
    parameter int unsigned CNT_SIZE = 16,
    parameter int unsigned IDX_W    = 3,
    parameter logic [7:0]  LEN      = 8'd18
) (
    input  rd_state_t                      state,
    input  logic [IDX_W-1:0]               idx,
    input  logic [7:0]                     frame_seq,
    input  logic [NUM_BINS*CNT_SIZE-1:0]   addr_snap,
    input  logic [NUM_BINS*CNT_SIZE-1:0]   vctr_snap,
    input  logic [15:0]                    addr_occ,
    input  logic [15:0]                    vctr_occ,
    input  logic [31:0]                    csum,
    output logic [31:0]                    word_c
);

    localparam int unsigned PAIR_W = 2 * CNT_SIZE;

    logic [PAIR_W-1:0] addr_pair;
    logic [PAIR_W-1:0] vctr_pair;

    // Select the bin pair {2k+1, 2k} for the current word index
    always_comb begin
        addr_pair = addr_snap[32'(idx) * PAIR_W +: PAIR_W];
        vctr_pair = vctr_snap[32'(idx) * PAIR_W +: PAIR_W];
    end

    // Build the outgoing word for the given state, zero-extending each bin to 16 bits
    always_comb begin
        word_c = '0;
        case (state)
            HDR:     word_c = {HDR_MAGIC, frame_seq, LEN};
            ADDR:    word_c = {16'(addr_pair[PAIR_W-1 -: CNT_SIZE]), 16'(addr_pair[CNT_SIZE-1:0])};
            VCTR:    word_c = {16'(vctr_pair[PAIR_W-1 -: CNT_SIZE]), 16'(vctr_pair[CNT_SIZE-1:0])};
            STAT:    word_c = {addr_occ, vctr_occ};
            CSUM:    word_c = csum;
            default: word_c = '0;
        endcase
    end

endmodule

// File: rtl/driver_monitor_readout.sv
// Snapshot-and-stream readout engine for the driver FIFO monitor statistics.
// Define DRV_MON_READOUT_CSUM_EN to append an XOR checksum word to every frame.
module driver_monitor_readout
    import drv_mon_pkg::*;
#(
    parameter int unsigned NUM_BINS = 16,
    parameter int unsigned CNT_SIZE = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          snap_req,
    input  logic                          end_program,
    input  logic [NUM_BINS*CNT_SIZE-1:0]  addr_bins,
    input  logic [NUM_BINS*CNT_SIZE-1:0]  vctr_bins,
    input  logic [15:0]                   words_in_addr_fifo,
    input  logic [15:0]                   words_in_vctr_fifo,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_data,
    output logic                          out_last,
    output logic                          busy,
    output logic [7:0]                    frame_seq,
    output logic [7:0]                    snap_drops
);

    localparam int unsigned HALF  = NUM_BINS / 2;
    localparam int unsigned IDX_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HALF - 1);

`ifdef DRV_MON_READOUT_CSUM_EN
    localparam bit        CSUM_EN = 1'b1;
    localparam rd_state_t LAST_ST = CSUM;
`else
    localparam bit        CSUM_EN = 1'b0;
    localparam rd_state_t LAST_ST = STAT;
`endif

    localparam logic [7:0] LEN = frame_len(NUM_BINS, CSUM_EN);

    rd_state_t                     state;
    rd_state_t                     nxt_state;
    logic [IDX_W-1:0]              idx;
    logic [IDX_W-1:0]              nxt_idx;
    logic                          end_program_d;
    logic                          trigger;
    logic                          xfer;
    logic                          capture;
    logic [NUM_BINS*CNT_SIZE-1:0]  addr_snap;
    logic [NUM_BINS*CNT_SIZE-1:0]  vctr_snap;
    logic [15:0]                   addr_occ;
    logic [15:0]                   vctr_occ;
    logic [31:0]                   csum_nxt;
    logic [31:0]                   word_c;

    assign trigger = snap_req | (end_program & ~end_program_d);
    assign xfer    = out_valid & out_ready;
    assign capture = (state == IDLE) & trigger;

`ifdef DRV_MON_READOUT_CSUM_EN
    logic [31:0] csum_q;

    // Running XOR includes the word transferring this cycle so CSUM covers STAT too
    assign csum_nxt = xfer ? (csum_q ^ out_data) : csum_q;

    // Checksum accumulator, cleared on capture
    always_ff @(posedge clk) begin
        if (!reset) begin
            csum_q <= '0;
        end else if (capture) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_nxt;
        end
    end
`else
    assign csum_nxt = '0;
`endif

    // Next state and word index; states advance only on a transfer
    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        case (state)
            IDLE: begin
                if (trigger) begin
                    nxt_state = HDR;
                    nxt_idx   = '0;
                end
            end
            HDR: begin
                if (xfer) nxt_state = ADDR;
            end
            ADDR: begin
                if (xfer) begin
                    if (idx == IDX_LAST) begin
                        nxt_state = VCTR;
                        nxt_idx   = '0;
                    end else begin
                        nxt_idx = idx + IDX_W'(1);
                    end
                end
            end
            VCTR: begin
                if (xfer) begin
                    if (idx == IDX_LAST) begin
                        nxt_state = STAT;
                        nxt_idx   = '0;
                    end else begin
                        nxt_idx = idx + IDX_W'(1);
                    end
                end
            end
            STAT: begin
`ifdef DRV_MON_READOUT_CSUM_EN
                if (xfer) nxt_state = CSUM;
`else
                if (xfer) nxt_state = IDLE;
`endif
            end
            CSUM: begin
                if (xfer) nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Word for the state being entered, so out_data can be registered
    driver_monitor_frame_mux #(
        .NUM_BINS (NUM_BINS),
        .CNT_SIZE (CNT_SIZE),
        .IDX_W    (IDX_W),
        .LEN      (LEN)
    ) u_frame_mux (
        .state     (nxt_state),
        .idx       (nxt_idx),
        .frame_seq (frame_seq),
        .addr_snap (addr_snap),
        .vctr_snap (vctr_snap),
        .addr_occ  (addr_occ),
        .vctr_occ  (vctr_occ),
        .csum      (csum_nxt),
        .word_c    (word_c)
    );

    // FSM state, snapshot capture, registered handshake outputs and counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            idx           <= '0;
            end_program_d <= 1'b0;
            addr_snap     <= '0;
            vctr_snap     <= '0;
            addr_occ      <= '0;
            vctr_occ      <= '0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            out_data      <= '0;
            busy          <= 1'b0;
            frame_seq     <= '0;
            snap_drops    <= '0;
        end else begin
            state         <= nxt_state;
            idx           <= nxt_idx;
            end_program_d <= end_program;
            out_valid     <= (nxt_state != IDLE);
            busy          <= (nxt_state != IDLE);

            if (capture) begin
                addr_snap <= addr_bins;
                vctr_snap <= vctr_bins;
                addr_occ  <= words_in_addr_fifo;
                vctr_occ  <= words_in_vctr_fifo;
            end

            if (trigger && (state != IDLE) && (snap_drops != 8'hFF)) begin
                snap_drops <= snap_drops + 8'd1;
            end

            if (capture || xfer) begin
                out_data <= word_c;
                out_last <= (nxt_state == LAST_ST);
            end

            if (xfer && out_last) begin
                frame_seq <= frame_seq + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_driver_monitor_readout.sv
// Scoreboard bench for driver_monitor_readout; honours DRV_MON_READOUT_CSUM_EN if defined.
module tb_driver_monitor_readout;

    localparam int unsigned NB = 16;
    localparam int unsigned CS = 16;
`ifdef DRV_MON_READOUT_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif
    localparam int LEN = NB + 2 + (CSUM ? 1 : 0);

    logic              clk = 1'b0;
    logic              reset;
    logic              snap_req;
    logic              end_program;
    logic [NB*CS-1:0]  addr_bins;
    logic [NB*CS-1:0]  vctr_bins;
    logic [15:0]       words_in_addr_fifo;
    logic [15:0]       words_in_vctr_fifo;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic              out_last;
    logic              busy;
    logic [7:0]        frame_seq;
    logic [7:0]        snap_drops;

    always #5 clk = ~clk;

    driver_monitor_readout #(.NUM_BINS(NB), .CNT_SIZE(CS)) dut (
        .clk                (clk),
        .reset              (reset),
        .snap_req           (snap_req),
        .end_program        (end_program),
        .addr_bins          (addr_bins),
        .vctr_bins          (vctr_bins),
        .words_in_addr_fifo (words_in_addr_fifo),
        .words_in_vctr_fifo (words_in_vctr_fifo),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .out_last           (out_last),
        .busy               (busy),
        .frame_seq          (frame_seq),
        .snap_drops         (snap_drops)
    );

    int errors = 0;
    int checks = 0;
    int model_seq = 0;
    int model_drops = 0;
    int rd_mode = 0;          // 0: always ready, 1: random, 2: stalled
    logic [32:0] exp_q[$];    // {last, data}
    logic [CS-1:0] a_bin[NB];
    logic [CS-1:0] v_bin[NB];

    always_comb begin
        for (int i = 0; i < int'(NB); i++) begin
            addr_bins[i*CS +: CS] = a_bin[i];
            vctr_bins[i*CS +: CS] = v_bin[i];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame built from the captured bins by the framing rules
    task automatic push_frame();
        logic [31:0] w;
        logic [31:0] x;
        x = '0;
        w = {16'hD0A5, 8'(model_seq), 8'(LEN)};
        exp_q.push_back({1'b0, w});
        x ^= w;
        for (int k = 0; k < int'(NB/2); k++) begin
            w = {16'(a_bin[2*k+1]), 16'(a_bin[2*k])};
            exp_q.push_back({1'b0, w});
            x ^= w;
        end
        for (int k = 0; k < int'(NB/2); k++) begin
            w = {16'(v_bin[2*k+1]), 16'(v_bin[2*k])};
            exp_q.push_back({1'b0, w});
            x ^= w;
        end
        w = {words_in_addr_fifo, words_in_vctr_fifo};
        exp_q.push_back({!CSUM, w});
        x ^= w;
        if (CSUM) exp_q.push_back({1'b1, x});
        model_seq = (model_seq + 1) % 256;
    endtask

    function automatic int sat_add(input int d, input int n);
        return (d + n > 255) ? 255 : d + n;
    endfunction

    // Ready driver, changes just after each rising edge
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rd_mode)
                1:       out_ready = ($urandom_range(0, 2) != 0);
                2:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops expected words on each transfer and checks stall stability
    logic        stall_prev = 1'b0;
    logic [32:0] stall_word;
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && out_valid) begin
                check("stall_hold", {31'd0, out_last, out_data}, {31'd0, stall_word});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none at %0t", out_data, $time);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("word_data", {32'd0, out_data}, {32'd0, e[31:0]});
                    check("word_last", {63'd0, out_last}, {63'd0, e[32]});
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_word = {out_last, out_data};
        end
    end

    // Issue one trigger from IDLE; kind: 0 snap_req, 1 end_program rise, 2 both
    task automatic pulse_snap(input int kind);
        snap_req    = (kind != 1);
        end_program = (kind != 0);
        push_frame();
        @(posedge clk);
        #1;
        snap_req    = 1'b0;
        end_program = 1'b0;
        check("latency_valid", {63'd0, out_valid}, 64'd1);
        check("latency_busy", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", {63'd0, n < 3000}, 64'd1);
        check("frame_seq", {56'd0, frame_seq}, 64'(model_seq));
    endtask

    task automatic rand_bins();
        for (int i = 0; i < int'(NB); i++) begin
            a_bin[i] = CS'($urandom);
            v_bin[i] = CS'($urandom);
        end
        words_in_addr_fifo = 16'($urandom);
        words_in_vctr_fifo = 16'($urandom);
    endtask

    task automatic plan_bins();
        for (int i = 0; i < int'(NB); i++) begin
            a_bin[i] = CS'(i + 1);
            v_bin[i] = CS'(16'h100 + i);
        end
        words_in_addr_fifo = 16'd5;
        words_in_vctr_fifo = 16'd7;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        snap_req    = 1'b0;
        end_program = 1'b0;
        plan_bins();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_last", {63'd0, out_last}, 64'd0);
        check("rst_data", {32'd0, out_data}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_seq", {56'd0, frame_seq}, 64'd0);
        check("rst_drops", {56'd0, snap_drops}, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame with the known pattern
        rd_mode = 0;
        pulse_snap(0);
        wait_done();

        // Backpressure on the same pattern
        rd_mode = 1;
        pulse_snap(0);
        wait_done();

        // Triggers while busy: snap_req then an end_program rise
        rd_mode = 0;
        pulse_snap(0);
        repeat (2) @(posedge clk);
        #1;
        snap_req = 1'b1;
        @(posedge clk);
        #1;
        snap_req = 1'b0;
        @(posedge clk);
        #1;
        end_program = 1'b1;
        model_drops = sat_add(model_drops, 2);
        wait_done();
        end_program = 1'b0;
        @(posedge clk);
        #1;
        check("busy_drops", {56'd0, snap_drops}, 64'(model_drops));

        // Trigger on the last transfer is a drop; held into the IDLE cycle it starts a frame
        pulse_snap(0);
        repeat (LEN - 1) @(posedge clk);
        #1;
        snap_req = 1'b1;
        model_drops = sat_add(model_drops, 1);
        @(posedge clk);
        #1;
        check("eof_idle_valid", {63'd0, out_valid}, 64'd0);
        push_frame();
        @(posedge clk);
        #1;
        snap_req = 1'b0;
        check("eof_retrigger_busy", {63'd0, busy}, 64'd1);
        wait_done();
        check("eof_drops", {56'd0, snap_drops}, 64'(model_drops));

        // Snapshot isolation
        rd_mode = 1;
        pulse_snap(0);
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(NB); i++) begin
            a_bin[i] = '1;
            v_bin[i] = '1;
        end
        words_in_addr_fifo = 16'hFFFF;
        words_in_vctr_fifo = 16'hFFFF;
        wait_done();

        // Random frames with mixed trigger sources
        for (int f = 0; f < 8; f++) begin
            rand_bins();
            rd_mode = 1;
            pulse_snap(int'($urandom_range(0, 2)));
            wait_done();
        end

        // Reset mid-frame during ADDR
        rd_mode = 0;
        rand_bins();
        pulse_snap(0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("midrst_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_last", {63'd0, out_last}, 64'd0);
        check("midrst_seq", {56'd0, frame_seq}, 64'd0);
        check("midrst_drops", {56'd0, snap_drops}, 64'd0);
        reset = 1'b1;
        model_seq = 0;
        model_drops = 0;
        @(posedge clk);
        #1;
        pulse_snap(0);
        wait_done();

        // Sequence wrap over 256 frames
        rd_mode = 0;
        for (int f = 0; f < 256; f++) begin
            if (f % 32 == 0) rand_bins();
            pulse_snap(0);
            wait_done();
        end

        // Drop counter saturation while stalled
        rand_bins();
        pulse_snap(0);
        rd_mode = 2;
        snap_req = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        snap_req = 1'b0;
        model_drops = sat_add(model_drops, 300);
        check("sat_drops", {56'd0, snap_drops}, 64'(model_drops));
        rd_mode = 0;
        wait_done();
        check("sat_drops_hold", {56'd0, snap_drops}, 64'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
